// File: rtl/peripheral_msi_pkg.sv
// Shared definitions for the MSI UART bus-master sequencer: register offsets, STATUS clear masks, FSM states.
package peripheral_msi_pkg;

    localparam logic [13:0] MSI_OFS_CTRL = 14'd0;
    localparam logic [13:0] MSI_OFS_BAUD = 14'd1;
    localparam logic [13:0] MSI_OFS_DATA = 14'd2;

    localparam logic [15:0] MSI_CLR_RX = 16'h0100;
    localparam logic [15:0] MSI_CLR_TX = 16'h0200;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_BAUD,
        ST_CFG_CTRL,
        ST_RUN,
        ST_RX_READ,
        ST_RX_CLR,
        ST_TX_WRITE,
        ST_TX_WAIT,
        ST_TX_CLR
    } msi_seq_state_t;

endpackage

// File: rtl/peripheral_msi_seq_fifo.sv
// Purpose: register-based FIFO with registered head, pointers wrap modulo DEPTH.
// Latency: a pushed word is visible on head_o the cycle after the push edge when the FIFO was empty.
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module peripheral_msi_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             push_acc_o,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok     = pop_i & ~empty_o;
    assign push_acc_o = push_i & (~full_o | pop_ok);
    assign wr_d       = wr_q + {{AW{1'b0}}, push_acc_o};
    assign rd_d       = rd_q + {{AW{1'b0}}, pop_ok};
    assign head_o     = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_acc_o) mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/peripheral_msi_sequencer.sv
// Purpose: configures the MSI UART after cfg_start, then moves bytes TX FIFO -> UART and UART -> RX FIFO.
// Latency: one bus access per state; TX byte reaches the bus 2 edges after handshake. Backpressure: tx_ready = TX FIFO not full; full RX FIFO drops bytes (sticky rx_overflow).
// Optional MSI_SEQ_STATS_EN adds tx_count/rx_count outputs.
module peripheral_msi_sequencer
    import peripheral_msi_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR  = 14'h0040,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_DIV   = 16'd868,
    parameter logic [7:0]  CTRL_INIT  = 8'h01
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        cfg_start,
    output logic        busy,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_overflow,
    output logic [13:0] m_per_addr,
    output logic [15:0] m_per_din,
    input  logic [15:0] m_per_dout,
    output logic        m_per_en,
    output logic [1:0]  m_per_we,
`ifdef MSI_SEQ_STATS_EN
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
`endif
    input  logic        irq_msi_rx,
    input  logic        irq_msi_tx
);
    msi_seq_state_t state_q, state_d;
    logic           ret_q, ret_d;
    logic           tx_free_q, tx_free_d;
    logic           rx_ovf_q, rx_ovf_d;
    logic           tx_full, tx_empty, tx_pop, tx_push_acc;
    logic [7:0]     tx_head;
    logic           rx_full, rx_empty, rx_push, rx_push_acc;
    logic           unused_dout_lo;
    logic           cfg_go;

    assign cfg_go         = cfg_start && (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign tx_ready       = (state_q != ST_IDLE) && !tx_full;
    assign rx_valid       = !rx_empty;
    assign rx_overflow    = rx_ovf_q;
    assign unused_dout_lo = ^m_per_dout[7:0];

    peripheral_msi_seq_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i      (mclk),
        .rst_n_i    (puc_rst_n),
        .push_i     (tx_valid & tx_ready),
        .push_dat_i (tx_data),
        .pop_i      (tx_pop),
        .push_acc_o (tx_push_acc),
        .head_o     (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    peripheral_msi_seq_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i      (mclk),
        .rst_n_i    (puc_rst_n),
        .push_i     (rx_push),
        .push_dat_i (m_per_dout[15:8]),
        .pop_i      (rx_ready),
        .push_acc_o (rx_push_acc),
        .head_o     (rx_data),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q   <= ST_IDLE;
            ret_q     <= 1'b0;
            tx_free_q <= 1'b0;
            rx_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            tx_free_q <= tx_free_d;
            rx_ovf_q  <= rx_ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        tx_free_d = tx_free_q;
        rx_ovf_d  = rx_ovf_q;
        unique case (state_q)
            ST_IDLE: if (cfg_start) begin
                state_d  = ST_CFG_BAUD;
                rx_ovf_d = 1'b0;
                ret_d    = 1'b0;
            end
            ST_CFG_BAUD: state_d = ST_CFG_CTRL;
            ST_CFG_CTRL: begin
                tx_free_d = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (irq_msi_rx)                 state_d = ST_RX_READ;
                else if (tx_free_q && !tx_empty) state_d = ST_TX_WRITE;
            end
            ST_RX_READ: begin
                if (!rx_push_acc) rx_ovf_d = 1'b1;
                state_d = ST_RX_CLR;
            end
            // A TX byte still in flight resumes waiting for its done flag.
            ST_RX_CLR: begin
                state_d = ret_q ? ST_TX_WAIT : ST_RUN;
                ret_d   = 1'b0;
            end
            ST_TX_WRITE: begin
                tx_free_d = 1'b0;
                state_d   = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (irq_msi_rx) begin
                    state_d = ST_RX_READ;
                    ret_d   = 1'b1;
                end else if (irq_msi_tx) begin
                    state_d = ST_TX_CLR;
                end
            end
            ST_TX_CLR: begin
                tx_free_d = 1'b1;
                state_d   = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_per_en   = 1'b0;
        m_per_we   = 2'b00;
        m_per_addr = '0;
        m_per_din  = '0;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        unique case (state_q)
            ST_CFG_BAUD: begin
                m_per_en = 1'b1; m_per_we = 2'b11;
                m_per_addr = BASE_ADDR + MSI_OFS_BAUD; m_per_din = BAUD_DIV;
            end
            ST_CFG_CTRL: begin
                m_per_en = 1'b1; m_per_we = 2'b01;
                m_per_addr = BASE_ADDR + MSI_OFS_CTRL; m_per_din = {8'h03, CTRL_INIT};
            end
            ST_RX_READ: begin
                m_per_en = 1'b1; m_per_addr = BASE_ADDR + MSI_OFS_DATA;
                rx_push  = 1'b1;
            end
            ST_RX_CLR: begin
                m_per_en = 1'b1; m_per_we = 2'b10;
                m_per_addr = BASE_ADDR + MSI_OFS_CTRL; m_per_din = MSI_CLR_RX;
            end
            ST_TX_WRITE: begin
                m_per_en = 1'b1; m_per_we = 2'b01;
                m_per_addr = BASE_ADDR + MSI_OFS_DATA; m_per_din = {8'h00, tx_head};
                tx_pop   = 1'b1;
            end
            ST_TX_CLR: begin
                m_per_en = 1'b1; m_per_we = 2'b10;
                m_per_addr = BASE_ADDR + MSI_OFS_CTRL; m_per_din = MSI_CLR_TX;
            end
            default: ;
        endcase
    end

`ifdef MSI_SEQ_STATS_EN
    logic [15:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else if (cfg_go) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_pop)                 tx_cnt_q <= tx_cnt_q + 16'd1;
            if (rx_push && rx_push_acc) rx_cnt_q <= rx_cnt_q + 16'd1;
        end
    end

    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;
`endif

endmodule

// File: tb/tb_peripheral_msi_sequencer.sv
// Directed self-checking bench for peripheral_msi_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_peripheral_msi_sequencer;

    logic        mclk = 1'b0;
    logic        puc_rst_n, cfg_start, busy;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, rx_overflow;
    logic [7:0]  tx_data, rx_data;
    logic [13:0] m_per_addr;
    logic [15:0] m_per_din, m_per_dout;
    logic        m_per_en;
    logic [1:0]  m_per_we;
    logic        irq_msi_rx, irq_msi_tx;
`ifdef MSI_SEQ_STATS_EN
    logic [15:0] tx_count, rx_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 mclk = ~mclk;

    peripheral_msi_sequencer dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .cfg_start   (cfg_start),
        .busy        (busy),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow),
        .m_per_addr  (m_per_addr),
        .m_per_din   (m_per_din),
        .m_per_dout  (m_per_dout),
        .m_per_en    (m_per_en),
        .m_per_we    (m_per_we),
`ifdef MSI_SEQ_STATS_EN
        .tx_count    (tx_count),
        .rx_count    (rx_count),
`endif
        .irq_msi_rx  (irq_msi_rx),
        .irq_msi_tx  (irq_msi_tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic en, input logic [1:0] we,
                           input logic [13:0] addr, input logic [15:0] din);
        chk({tag, ".en"},   32'(m_per_en),   32'(en));
        chk({tag, ".we"},   32'(m_per_we),   32'(we));
        chk({tag, ".addr"}, 32'(m_per_addr), 32'(addr));
        chk({tag, ".din"},  32'(m_per_din),  32'(din));
    endtask

    task automatic ne();
        @(negedge mclk);
    endtask

    initial begin
        puc_rst_n = 1'b0; cfg_start = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rx_ready = 1'b0; m_per_dout = 16'h0000; irq_msi_rx = 1'b0; irq_msi_tx = 1'b0;
        ne(); ne();
        chk_bus("reset", 1'b0, 2'b00, 14'h0000, 16'h0000);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.tx_ready", 32'(tx_ready), 32'd0);
        chk("reset.rx_valid", 32'(rx_valid), 32'd0);
        chk("reset.rx_overflow", 32'(rx_overflow), 32'd0);
        puc_rst_n = 1'b1;

        // Configuration: BAUD then CTRL, then RUN.
        ne(); cfg_start = 1'b1;
        ne(); cfg_start = 1'b0;
        chk_bus("cfg_baud", 1'b1, 2'b11, 14'h0041, 16'h0364);
        chk("cfg_baud.busy", 32'(busy), 32'd1);
        ne(); chk_bus("cfg_ctrl", 1'b1, 2'b01, 14'h0040, 16'h0301);
        ne(); chk_bus("run_idle", 1'b0, 2'b00, 14'h0000, 16'h0000);
        chk("run.busy", 32'(busy), 32'd0);
        chk("run.tx_ready", 32'(tx_ready), 32'd1);

        // TX byte A5: bus write two edges after handshake; second byte waits for TX_CLR.
        tx_valid = 1'b1; tx_data = 8'hA5;
        ne(); tx_valid = 1'b0;
        chk("tx_lat.en_gap", 32'(m_per_en), 32'd0);
        ne(); chk_bus("tx_write_a5", 1'b1, 2'b01, 14'h0042, 16'h00A5);
        tx_valid = 1'b1; tx_data = 8'h3C;
        ne(); tx_valid = 1'b0;
        chk("tx_wait.en", 32'(m_per_en), 32'd0);
        ne(); chk("tx_wait_hold.en", 32'(m_per_en), 32'd0);
        chk("tx_wait.busy", 32'(busy), 32'd1);
        irq_msi_tx = 1'b1;
        ne(); chk_bus("tx_clr", 1'b1, 2'b10, 14'h0040, 16'h0200);
        irq_msi_tx = 1'b0;
        ne(); chk("run_before_3c.en", 32'(m_per_en), 32'd0);
        ne(); chk_bus("tx_write_3c", 1'b1, 2'b01, 14'h0042, 16'h003C);
        irq_msi_tx = 1'b1;
        ne(); chk("tx_wait_3c.en", 32'(m_per_en), 32'd0);
        ne(); chk_bus("tx_clr_3c", 1'b1, 2'b10, 14'h0040, 16'h0200);
        irq_msi_tx = 1'b0;
        ne();

        // Single RX byte.
        irq_msi_rx = 1'b1; m_per_dout = 16'h5A00;
        ne(); chk_bus("rx_read", 1'b1, 2'b00, 14'h0042, 16'h0000);
        irq_msi_rx = 1'b0;
        ne(); chk_bus("rx_clr", 1'b1, 2'b10, 14'h0040, 16'h0100);
        chk("rx.valid", 32'(rx_valid), 32'd1);
        chk("rx.data", 32'(rx_data), 32'h5A);
        ne(); chk("rx_run.busy", 32'(busy), 32'd0);
        rx_ready = 1'b1;
        ne(); rx_ready = 1'b0;
        chk("rx_pop.valid", 32'(rx_valid), 32'd0);

        // Fill RX FIFO with 10..17, then overflow with EE.
        for (int i = 0; i < 9; i++) begin
            irq_msi_rx = 1'b1;
            m_per_dout = (i < 8) ? {8'h10 + 8'(i), 8'h00} : 16'hEE00;
            ne(); irq_msi_rx = 1'b0;
            ne(); ne();
            if (i == 7) chk("fill.overflow", 32'(rx_overflow), 32'd0);
        end
        chk("ovf.overflow", 32'(rx_overflow), 32'd1);
        chk("ovf.head", 32'(rx_data), 32'h10);
        cfg_start = 1'b1;
        ne(); cfg_start = 1'b0;
        chk("cfg_ignored.busy", 32'(busy), 32'd0);
        chk("cfg_ignored.overflow", 32'(rx_overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("drain.valid", 32'(rx_valid), 32'd1);
            chk("drain.data", 32'(rx_data), 32'h10 + 32'(i));
            rx_ready = 1'b1;
            ne();
        end
        rx_ready = 1'b0;
        chk("drain.empty", 32'(rx_valid), 32'd0);

        // RX has priority in TX_WAIT and returns to TX_WAIT before TX_CLR; reset aborts TX_CLR.
        tx_valid = 1'b1; tx_data = 8'h77;
        ne(); tx_valid = 1'b0;
        ne(); chk_bus("tx_write_77", 1'b1, 2'b01, 14'h0042, 16'h0077);
        ne(); irq_msi_rx = 1'b1; irq_msi_tx = 1'b1; m_per_dout = 16'h6600;
        ne(); chk_bus("prio.rx_read", 1'b1, 2'b00, 14'h0042, 16'h0000);
        irq_msi_rx = 1'b0;
        ne(); chk_bus("prio.rx_clr", 1'b1, 2'b10, 14'h0040, 16'h0100);
        ne(); chk("prio.back_to_wait.en", 32'(m_per_en), 32'd0);
        chk("prio.back_to_wait.busy", 32'(busy), 32'd1);
        ne(); chk_bus("prio.tx_clr", 1'b1, 2'b10, 14'h0040, 16'h0200);
        chk("prio.rx_data", 32'(rx_data), 32'h66);
`ifdef MSI_SEQ_STATS_EN
        chk("stats.tx_count", 32'(tx_count), 32'd3);
        chk("stats.rx_count", 32'(rx_count), 32'd10);
`endif
        irq_msi_tx = 1'b0;
        puc_rst_n = 1'b0;
        #1;
        chk_bus("abort", 1'b0, 2'b00, 14'h0000, 16'h0000);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.tx_ready", 32'(tx_ready), 32'd0);
        chk("abort.rx_valid", 32'(rx_valid), 32'd0);
`ifdef MSI_SEQ_STATS_EN
        chk("abort.tx_count", 32'(tx_count), 32'd0);
        chk("abort.rx_count", 32'(rx_count), 32'd0);
`endif
        ne(); puc_rst_n = 1'b1;
        ne(); chk("idle.tx_ready", 32'(tx_ready), 32'd0);
        cfg_start = 1'b1;
        ne(); cfg_start = 1'b0;
        chk_bus("recfg_baud", 1'b1, 2'b11, 14'h0041, 16'h0364);
        ne(); ne();
        chk("recfg.busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
